rover_drive_ctrl: RTL and testbench

Sequences the rover's H-bridge: converts forward/reverse operator commands and a 2-bit speed select into the 4-bit `Direction` drive code and a PWM enable, with a dead-time interval on every stop or reversal and an overcurrent shutdown driven by the current-sense comparators. It sits between the switch/button inputs and the motor driver pins. Its `Direction` output also feeds the seven-segment status display, which decodes 1001 and 0110.

---
 rtl/rover_pkg.sv | 28 ++
 rtl/pwm_gen.sv | 28 ++
 rtl/rover_drive_ctrl.sv | 121 ++++++++++++
 tb/tb_rover_drive_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rover_pkg.sv
// Shared definitions for the rover H-bridge controller and the status display decoder.
package rover_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    REV,
    DEAD,
    FAULT
  } state_t;

  localparam logic [3:0] DIR_FWD = 4'b1001;
  localparam logic [3:0] DIR_REV = 4'b0110;
  localparam logic [3:0] DIR_OFF = 4'b0000;

  // Duty at 12-bit resolution; callers rescale for other PWM widths.
  function automatic logic [11:0] speed_to_duty(input logic [1:0] speed_sel);
    logic [11:0] duty;
    case (speed_sel)
      2'b00:   duty = 12'd0;
      2'b01:   duty = 12'd1024;
      2'b10:   duty = 12'd2048;
      default: duty = 12'd4095;
    endcase
    return duty;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a registered compare against duty, gated by enable.
module pwm_gen #(
  parameter int PWM_BITS = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                enable,
  output logic                pwm
);

  logic [PWM_BITS-1:0] cnt_reg;
  logic                pwm_reg;

  // The counter never restarts on drive changes, so the phase is continuous.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      pwm_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_reg + PWM_BITS'(1);
      pwm_reg <= enable && (cnt_reg < duty);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/rover_drive_ctrl.sv
// H-bridge sequencer: forward/reverse drive with dead time between drive states,
// a filtered overcurrent trip latching FAULT, and a PWM bridge enable.
module rover_drive_ctrl
  import rover_pkg::*;
#(
  parameter int PWM_BITS    = 12,
  parameter int DEAD_CYCLES = 100000,
  parameter int OC_FILTER   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fwd_cmd,
  input  logic       rev_cmd,
  input  logic [1:0] speed_sel,
  input  logic       SensorA,
  input  logic       SensorB,
  input  logic       fault_clr,
  output logic [3:0] Direction,
  output logic       pwm,
  output logic       fault
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam int OW = $clog2(OC_FILTER + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [OW-1:0] OC_MAX    = OW'(OC_FILTER);

  state_t        state_reg;
  logic [DW-1:0] dead_cnt_reg;
  logic [OW-1:0] oc_cnt_reg;
  logic [3:0]    direction_reg;
  logic          fault_reg;

  logic go_fwd, go_rev, oc_hi, clear_ok, drive_en;
  logic [11:0]         base_duty;
  logic [PWM_BITS-1:0] duty;

  assign go_fwd   = fwd_cmd & ~rev_cmd;
  assign go_rev   = rev_cmd & ~fwd_cmd;
  assign oc_hi    = SensorA | SensorB;
  assign clear_ok = fault_clr & ~SensorA & ~SensorB & ~fwd_cmd & ~rev_cmd;
  assign drive_en = (state_reg == FWD) || (state_reg == REV);

  assign base_duty = speed_to_duty(speed_sel);

  generate
    if (PWM_BITS >= 12) begin : g_duty_up
      assign duty = PWM_BITS'(base_duty) << (PWM_BITS - 12);
    end else begin : g_duty_down
      assign duty = PWM_BITS'(base_duty >> (12 - PWM_BITS));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      dead_cnt_reg  <= '0;
      oc_cnt_reg    <= '0;
      direction_reg <= DIR_OFF;
      fault_reg     <= 1'b0;
    end else begin
      if (!oc_hi)
        oc_cnt_reg <= '0;
      else if (oc_cnt_reg != OC_MAX)
        oc_cnt_reg <= oc_cnt_reg + OW'(1);

      direction_reg <= (state_reg == FWD) ? DIR_FWD :
                       (state_reg == REV) ? DIR_REV : DIR_OFF;
      fault_reg     <= (state_reg == FAULT);

      // A saturated overcurrent count wins over every other transition.
      if (oc_cnt_reg == OC_MAX) begin
        state_reg <= FAULT;
      end else begin
        case (state_reg)
          IDLE: begin
            if (go_fwd)      state_reg <= FWD;
            else if (go_rev) state_reg <= REV;
          end
          FWD: begin
            if (!go_fwd) begin
              state_reg    <= DEAD;
              dead_cnt_reg <= DEAD_LOAD;
            end
          end
          REV: begin
            if (!go_rev) begin
              state_reg    <= DEAD;
              dead_cnt_reg <= DEAD_LOAD;
            end
          end
          DEAD: begin
            if (dead_cnt_reg == '0) state_reg <= IDLE;
            else                    dead_cnt_reg <= dead_cnt_reg - DW'(1);
          end
          FAULT: begin
            if (clear_ok) begin
              state_reg    <= DEAD;
              dead_cnt_reg <= DEAD_LOAD;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm_gen (
    .clk   (clk),
    .reset (reset),
    .duty  (duty),
    .enable(drive_en),
    .pwm   (pwm)
  );

  assign Direction = direction_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_rover_drive_ctrl.sv
// Directed bench for rover_drive_ctrl with a small dead time and OC filter.
module tb_rover_drive_ctrl;

  logic       clk = 1'b0;
  logic       reset, fwd_cmd, rev_cmd, SensorA, SensorB, fault_clr;
  logic [1:0] speed_sel;
  logic [3:0] direction;
  logic       pwm, fault;
  logic [15:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  localparam logic [15:0] V_OFF = 16'h0000;
  localparam logic [15:0] V_FWD = {10'd0, 4'b1001, 2'b00};
  localparam logic [15:0] V_REV = {10'd0, 4'b0110, 2'b00};
  localparam logic [15:0] V_FLT = {10'd0, 4'b0000, 2'b01};

  always #5 clk = ~clk;

  assign obs = {10'd0, direction, pwm, fault};

  rover_drive_ctrl #(
    .PWM_BITS   (12),
    .DEAD_CYCLES(8),
    .OC_FILTER  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .fwd_cmd  (fwd_cmd),
    .rev_cmd  (rev_cmd),
    .speed_sel(speed_sel),
    .SensorA  (SensorA),
    .SensorB  (SensorB),
    .fault_clr(fault_clr),
    .Direction(direction),
    .pwm      (pwm),
    .fault    (fault)
  );

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [15:0] o);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h required an expectation", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [15:0] v);
    push(tag, v);
    tick();
    chk(obs);
  endtask

  task automatic count_pwm(input string tag, input logic [15:0] v);
    int hi;
    hi = 0;
    tick();
    repeat (4096) begin
      tick();
      if (pwm) hi++;
    end
    push(tag, v);
    chk(16'(hi));
  endtask

  initial begin
    reset = 1'b1; fwd_cmd = 1'b1; rev_cmd = 1'b0; speed_sel = 2'b11;
    SensorA = 1'b0; SensorB = 1'b0; fault_clr = 1'b0;
    repeat (2) tick();
    step_chk("rst_hold", V_OFF);

    reset = 1'b0; speed_sel = 2'b00;
    step_chk("rel_plus1", V_OFF);
    step_chk("rel_plus2", V_FWD);

    repeat (48) tick();
    fwd_cmd = 1'b0; rev_cmd = 1'b1;
    push("rev_first", V_FWD);
    for (int i = 0; i < 9; i++) push("rev_dead", V_OFF);
    push("rev_drive", V_REV);
    repeat (11) begin
      tick();
      chk(obs);
    end

    rev_cmd = 1'b0; fwd_cmd = 1'b1;
    repeat (10) tick();
    step_chk("back_fwd", V_FWD);

    speed_sel = 2'b01;
    count_pwm("pwm_duty_01", 16'd1024);
    speed_sel = 2'b00;
    count_pwm("pwm_duty_00", 16'd0);
    speed_sel = 2'b11;
    count_pwm("pwm_duty_11", 16'd4095);
    speed_sel = 2'b00;
    tick();
    step_chk("fwd_after_pwm", V_FWD);

    SensorA = 1'b1;
    repeat (3) step_chk("oc_burst1", V_FWD);
    SensorA = 1'b0;
    step_chk("oc_gap", V_FWD);
    SensorA = 1'b1;
    repeat (4) step_chk("oc_burst2", V_FWD);
    step_chk("oc_trip_edge", V_FWD);
    step_chk("oc_fault", V_FLT);

    SensorA = 1'b0; SensorB = 1'b1; fwd_cmd = 1'b0; fault_clr = 1'b1;
    repeat (3) step_chk("hold_sensorB", V_FLT);
    SensorB = 1'b0; fwd_cmd = 1'b1;
    repeat (3) step_chk("hold_fwd", V_FLT);
    fwd_cmd = 1'b0;
    step_chk("clr_edge", V_FLT);
    fault_clr = 1'b0; fwd_cmd = 1'b1;
    for (int i = 0; i < 9; i++) push("clr_dead", V_OFF);
    push("clr_fwd", V_FWD);
    repeat (10) begin
      tick();
      chk(obs);
    end

    rev_cmd = 1'b1;
    step_chk("both_fwd_edge", V_FWD);
    step_chk("both_to_dead", V_OFF);
    repeat (10) tick();
    repeat (3) step_chk("both_idle", V_OFF);

    rev_cmd = 1'b0;
    repeat (11) tick();
    step_chk("drive_before_rst", V_FWD);
    reset = 1'b1;
    step_chk("rst_mid_drive", V_OFF);
    reset = 1'b0; fwd_cmd = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
